// File: rtl/line_mem_server.sv
`default_nettype none
// line_mem_server: line store for the rotation controller; LOAD from a stream, SERVE line reads/writes, DUMP to a stream.
// Optional LINE_MEM_PARITY_EN: each entry carries an even-parity bit that is checked on every SERVE/DUMP read.
module line_mem_server #(
    parameter int LINE_W = 25,
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic              in_valid_i,
    input  logic [LINE_W-1:0] in_data_i,
    output logic              in_ready_o,
    input  logic              rd_req_i,
    output logic              rd_ack_o,
    output logic [LINE_W-1:0] line_o,
    output logic [ADDR_W-1:0] line_idx_o,
    input  logic              wr_req_i,
    input  logic [LINE_W-1:0] wr_data_i,
    output logic              wr_ack_o,
    output logic              done_o,
    output logic              out_valid_o,
    output logic [LINE_W-1:0] out_data_o,
    input  logic              out_ready_i,
    output logic              busy_o,
    output logic              err_o
);

`ifdef LINE_MEM_PARITY_EN
    localparam int MEM_W = LINE_W + 1;
`else
    localparam int MEM_W = LINE_W;
`endif
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_SERVE = 2'd2,
        S_DUMP  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W-1:0] out_ptr_q, out_ptr_d;
    logic              rd_ack_q, rd_ack_d;
    logic              wr_ack_q, wr_ack_d;
    logic              done_q, done_d;
    logic              out_valid_q, out_valid_d;
    logic              err_q, err_d;
    logic [LINE_W-1:0] line_q, line_d;
    logic [ADDR_W-1:0] line_idx_q, line_idx_d;
    logic [LINE_W-1:0] out_data_q, out_data_d;

    logic [MEM_W-1:0]  mem [DEPTH];
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [MEM_W-1:0]  mem_wdata;
    logic [MEM_W-1:0]  rd_entry;
    logic [MEM_W-1:0]  out_entry;
    logic [ADDR_W-1:0] out_raddr;
    logic              rd_par_err;
    logic              out_par_err;

    function automatic logic [MEM_W-1:0] encode(input logic [LINE_W-1:0] d);
`ifdef LINE_MEM_PARITY_EN
        return {^d, d};
`else
        return d;
`endif
    endfunction

    // While a line is presented, the next fetch targets the following slot.
    assign out_raddr = out_valid_q ? out_ptr_q + ADDR_W'(1) : out_ptr_q;
    assign rd_entry  = mem[rd_ptr_q];
    assign out_entry = mem[out_raddr];

`ifdef LINE_MEM_PARITY_EN
    assign rd_par_err  = ^rd_entry;
    assign out_par_err = ^out_entry;
`else
    assign rd_par_err  = 1'b0;
    assign out_par_err = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        out_ptr_d   = out_ptr_q;
        rd_ack_d    = 1'b0;
        wr_ack_d    = 1'b0;
        done_d      = 1'b0;
        out_valid_d = out_valid_q;
        err_d       = err_q;
        line_d      = line_q;
        line_idx_d  = line_idx_q;
        out_data_d  = out_data_q;
        mem_we      = 1'b0;
        mem_waddr   = wr_ptr_q;
        mem_wdata   = encode(in_data_i);

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d   = S_LOAD;
                    err_d     = 1'b0;
                    wr_ptr_d  = '0;
                    rd_ptr_d  = '0;
                    out_ptr_d = '0;
                end
            end
            S_LOAD: begin
                if (in_valid_i) begin
                    mem_we   = 1'b1;
                    wr_ptr_d = wr_ptr_q + ADDR_W'(1);
                    if (wr_ptr_q == LAST) state_d = S_SERVE;
                end
            end
            S_SERVE: begin
                // The read samples the array before this edge's write lands: read-before-write.
                if (rd_req_i) begin
                    rd_ack_d   = 1'b1;
                    line_d     = rd_entry[LINE_W-1:0];
                    line_idx_d = rd_ptr_q;
                    rd_ptr_d   = rd_ptr_q + ADDR_W'(1);
                    if (rd_par_err) err_d = 1'b1;
                end
                if (wr_req_i) begin
                    mem_we    = 1'b1;
                    mem_wdata = encode(wr_data_i);
                    wr_ack_d  = 1'b1;
                    wr_ptr_d  = wr_ptr_q + ADDR_W'(1);
                    if (wr_ptr_q == LAST) begin
                        done_d  = 1'b1;
                        state_d = S_DUMP;
                    end
                end
            end
            S_DUMP: begin
                if (!out_valid_q) begin
                    out_valid_d = 1'b1;
                    out_data_d  = out_entry[LINE_W-1:0];
                    if (out_par_err) err_d = 1'b1;
                end else if (out_ready_i) begin
                    if (out_ptr_q == LAST) begin
                        out_valid_d = 1'b0;
                        out_ptr_d   = '0;
                        state_d     = S_IDLE;
                    end else begin
                        out_ptr_d  = out_ptr_q + ADDR_W'(1);
                        out_data_d = out_entry[LINE_W-1:0];
                        if (out_par_err) err_d = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if ((rd_req_i || wr_req_i) && (state_q != S_SERVE)) err_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            out_ptr_q   <= '0;
            rd_ack_q    <= 1'b0;
            wr_ack_q    <= 1'b0;
            done_q      <= 1'b0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
            line_q      <= '0;
            line_idx_q  <= '0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            out_ptr_q   <= out_ptr_d;
            rd_ack_q    <= rd_ack_d;
            wr_ack_q    <= wr_ack_d;
            done_q      <= done_d;
            out_valid_q <= out_valid_d;
            err_q       <= err_d;
            line_q      <= line_d;
            line_idx_q  <= line_idx_d;
            out_data_q  <= out_data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
    end

    assign in_ready_o  = (state_q == S_LOAD);
    assign busy_o      = (state_q != S_IDLE);
    assign rd_ack_o    = rd_ack_q;
    assign line_o      = line_q;
    assign line_idx_o  = line_idx_q;
    assign wr_ack_o    = wr_ack_q;
    assign done_o      = done_q;
    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign err_o       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_line_mem_server.sv
`default_nettype none
// tb_line_mem_server: randomized stimulus checked every cycle against an array/counter model of the line server.
module tb_line_mem_server;
    localparam int LW = 25;
    localparam int D  = 64;
    localparam int AW = 6;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0, in_valid = 1'b0, rd_req = 1'b0, wr_req = 1'b0, out_ready = 1'b0;
    logic [LW-1:0] in_data = '0, wr_data = '0;
    logic          in_ready_o, rd_ack_o, wr_ack_o, done_o, out_valid_o, busy_o, err_o;
    logic [LW-1:0] line_o, out_data_o;
    logic [AW-1:0] line_idx_o;

    line_mem_server #(.LINE_W(LW), .DEPTH(D), .ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start),
        .in_valid_i(in_valid), .in_data_i(in_data), .in_ready_o(in_ready_o),
        .rd_req_i(rd_req), .rd_ack_o(rd_ack_o), .line_o(line_o), .line_idx_o(line_idx_o),
        .wr_req_i(wr_req), .wr_data_i(wr_data), .wr_ack_o(wr_ack_o), .done_o(done_o),
        .out_valid_o(out_valid_o), .out_data_o(out_data_o), .out_ready_i(out_ready),
        .busy_o(busy_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: phase 0 idle, 1 load, 2 serve, 3 dump; memory as a plain array.
    int            phase;
    logic [LW-1:0] m_mem [D];
    int            m_wp, m_rp, dump_cnt;
    logic          e_rd_ack, e_wr_ack, e_done, e_err, e_ov;
    logic [LW-1:0] e_line;
    logic [AW-1:0] e_idx;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase <= 0; m_wp <= 0; m_rp <= 0; dump_cnt <= 0;
            e_rd_ack <= 1'b0; e_wr_ack <= 1'b0; e_done <= 1'b0; e_err <= 1'b0; e_ov <= 1'b0;
            e_line <= '0; e_idx <= '0;
        end else begin
            e_rd_ack <= 1'b0;
            e_wr_ack <= 1'b0;
            e_done   <= 1'b0;
            case (phase)
                0: if (start) begin
                    phase <= 1; m_wp <= 0; m_rp <= 0; e_err <= 1'b0;
                end
                1: if (in_valid) begin
                    m_mem[m_wp] <= in_data;
                    m_wp <= (m_wp + 1) % D;
                    if (m_wp == D - 1) phase <= 2;
                end
                2: begin
                    if (rd_req) begin
                        e_rd_ack <= 1'b1;
                        e_line   <= m_mem[m_rp];
                        e_idx    <= AW'(m_rp);
                        m_rp     <= (m_rp + 1) % D;
                    end
                    if (wr_req) begin
                        m_mem[m_wp] <= wr_data;
                        e_wr_ack <= 1'b1;
                        m_wp <= (m_wp + 1) % D;
                        if (m_wp == D - 1) begin
                            e_done <= 1'b1; phase <= 3; dump_cnt <= 0;
                        end
                    end
                end
                3: begin
                    if (!e_ov) e_ov <= 1'b1;
                    else if (out_ready) begin
                        if (dump_cnt == D - 1) begin
                            e_ov <= 1'b0; phase <= 0; dump_cnt <= 0;
                        end else dump_cnt <= dump_cnt + 1;
                    end
                end
                default: ;
            endcase
            if ((rd_req || wr_req) && phase != 2) e_err <= 1'b1;
        end
    end

    int done_cnt = 0, wack_cnt = 0, xfer_cnt = 0;

    always @(negedge clk) begin
        check("busy", 32'(busy_o), 32'(phase != 0));
        check("in_ready", 32'(in_ready_o), 32'(phase == 1));
        check("rd_ack", 32'(rd_ack_o), 32'(e_rd_ack));
        if (e_rd_ack) begin
            check("line", 32'(line_o), 32'(e_line));
            check("line_idx", 32'(line_idx_o), 32'(e_idx));
        end
        check("wr_ack", 32'(wr_ack_o), 32'(e_wr_ack));
        check("done", 32'(done_o), 32'(e_done));
        check("err", 32'(err_o), 32'(e_err));
        check("out_valid", 32'(out_valid_o), 32'(e_ov));
        if (e_ov) check("out_data", 32'(out_data_o), 32'(m_mem[dump_cnt]));
        if (done_o) done_cnt++;
        if (wr_ack_o) wack_cnt++;
        if (out_valid_o && out_ready) xfer_cnt++;
    end

    task automatic load_lines(input bit seq, input int base);
        int  n = 0;
        bit  xfer;
        for (int c = 0; c < 1000 && n < D; c++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_data  = seq ? LW'(base + n) : LW'($urandom);
            xfer     = in_valid && in_ready_o;
            tick();
            if (xfer) n++;
        end
        in_valid = 1'b0;
        check("load_count", 32'(n), 32'(D));
    endtask

    initial begin
        int  rp, wcnt;
        bit  first_seen;

        repeat (3) tick();
        check("rst_busy", 32'(busy_o), 0);
        check("rst_in_ready", 32'(in_ready_o), 0);
        check("rst_out_valid", 32'(out_valid_o), 0);
        check("rst_err", 32'(err_o), 0);
        rst_n = 1'b1;
        tick();

        start = 1'b1; tick(); start = 1'b0;
        check("load_in_ready", 32'(in_ready_o), 1);
        load_lines(1'b1, 0);
        check("serve_busy", 32'(busy_o), 1);
        check("serve_in_ready", 32'(in_ready_o), 0);
        check("serve_err", 32'(err_o), 0);

        rd_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rd3_ack", 32'(rd_ack_o), 1);
            check("rd3_line", 32'(line_o), 32'(i));
            check("rd3_idx", 32'(line_idx_o), 32'(i));
            if (i == 2) rd_req = 1'b0;
        end
        rd_req = 1'b1; tick(); tick(); rd_req = 1'b0;

        wr_req = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wr_data = ~LW'(i);
            tick();
        end
        wr_req = 1'b0;

        rd_req = 1'b1; wr_req = 1'b1; wr_data = 25'h1FFFFFF;
        tick();
        check("coll_old_line", 32'(line_o), 32'd5);
        check("coll_idx", 32'(line_idx_o), 32'd5);
        rd_req = 1'b0; wr_req = 1'b0;

        rp = 6; wcnt = 6;
        for (int c = 0; c < 2000 && rp != 5; c++) begin
            rd_req  = ($urandom_range(0, 3) != 0);
            wr_req  = (wcnt < 40) && ($urandom_range(0, 3) == 0);
            wr_data = LW'($urandom);
            tick();
            if (rd_req) rp = (rp + 1) % D;
            if (wr_req) wcnt++;
        end
        rd_req = 1'b0; wr_req = 1'b0;
        check("wrap_reached", 32'(rp), 32'd5);
        rd_req = 1'b1; tick(); rd_req = 1'b0;
        check("reread_line", 32'(line_o), 32'h1FFFFFF);
        check("reread_idx", 32'(line_idx_o), 32'd5);

        for (int c = 0; c < 2000 && wcnt < D; c++) begin
            wr_req  = ($urandom_range(0, 3) != 0);
            rd_req  = ($urandom_range(0, 1) != 0);
            wr_data = ~LW'(wcnt);
            tick();
            if (wr_req) wcnt++;
        end
        check("last_done", 32'(done_o), 1);
        check("last_wr_ack", 32'(wr_ack_o), 1);
        wr_req = 1'b0; rd_req = 1'b0;

        first_seen = 1'b0;
        for (int c = 0; c < 1000; c++) begin
            out_ready = ($urandom_range(0, 1) != 0);
            tick();
            if (!first_seen && out_valid_o) begin
                check("dump_first", 32'(out_data_o), 32'h1FFFFFF);
                first_seen = 1'b1;
            end
            if (!busy_o) break;
        end
        out_ready = 1'b0;
        check("dump_idle", 32'(busy_o), 0);
        check("dump_xfers", 32'(xfer_cnt), 32'(D));
        check("done_pulses", 32'(done_cnt), 1);
        check("wr_acks", 32'(wack_cnt), 32'(D));

        rd_req = 1'b1; tick(); rd_req = 1'b0;
        check("idle_rd_noack", 32'(rd_ack_o), 0);
        check("idle_rd_err", 32'(err_o), 1);
        start = 1'b1; tick(); start = 1'b0;
        check("start_clr_err", 32'(err_o), 0);
        load_lines(1'b0, 0);
        rd_req = 1'b1; tick(); tick();
        #2 rst_n = 1'b0;
        #1;
        check("async_busy", 32'(busy_o), 0);
        check("async_rd_ack", 32'(rd_ack_o), 0);
        check("async_line", 32'(line_o), 0);
        rd_req = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        start = 1'b1; tick(); start = 1'b0;
        load_lines(1'b1, 100);
        rd_req = 1'b1; tick(); rd_req = 1'b0;
        check("restart_line", 32'(line_o), 32'd100);
        check("restart_idx", 32'(line_idx_o), 0);
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule
`default_nettype wire
